// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//   ID-stage branch sequencer. Holds the front end (PC, IF/ID) and bubbles
//   ID/EX until the operands of a branch-class instruction in ID can be
//   obtained. Selects MEM-stage forwarding for branch operands. Redirects
//   the PC and flushes IF/ID on a taken branch. Keeps saturating
//   branch/taken/stall performance counters.
//
// Handshake / timing contract:
//   All stall/flush/select/forward outputs are combinational functions of
//   the registered FSM state and the current-cycle inputs. ext_stall freezes
//   the FSM and the counters, but the outputs keep their normal values; the
//   surrounding pipeline gates its own register enables with ext_stall.
//
// Ports:
//   clk, rst               clock (rising edge), async active-low reset
//   id_valid/op/func/rs/rt instruction currently in ID
//   branch                 taken decision from the branch decision unit
//   ex_wreg/waddr/load     EX-stage producer
//   mem_wreg/waddr/load    MEM-stage producer
//   ext_stall              global freeze
//   pc_stall, ifid_stall   hold PC / IF-ID
//   idex_bubble            load NOP into ID/EX
//   ifid_flush             clear IF/ID at next edge
//   pc_sel                 1 = branch target, 0 = PC+4
//   fwd_rs, fwd_rt         take operand from MEM-stage ALU result
//   br_count, taken_count, stall_count   saturating performance counters
//   state_dbg, rem_dbg     FSM state and remaining-stall bit, for checkers
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter bit DELAY_SLOT = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_func,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             branch,
  input  logic             ex_wreg,
  input  logic [4:0]       ex_waddr,
  input  logic             ex_load,
  input  logic             mem_wreg,
  input  logic [4:0]       mem_waddr,
  input  logic             mem_load,
  input  logic             ext_stall,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pc_sel,
  output logic             fwd_rs,
  output logic             fwd_rt,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [0:0]       state_dbg,
  output logic             rem_dbg
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_TEQ     = 6'b110100;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0] state, state_nx;
  logic       rem, rem_nx;

  // Instruction class decode
  logic is_two_reg, is_one_reg, is_no_reg, is_br;
  logic use_rs, use_rt;

  assign is_two_reg = (id_op == OP_BEQ) || (id_op == OP_BNE) ||
                      (id_op == OP_SPECIAL && id_func == FN_TEQ);
  assign is_one_reg = (id_op == OP_REGIMM) ||
                      (id_op == OP_SPECIAL && (id_func == FN_JR || id_func == FN_JALR));
  assign is_no_reg  = (id_op == OP_J) || (id_op == OP_JAL);
  assign is_br      = id_valid && (is_two_reg || is_one_reg || is_no_reg);
  assign use_rs     = id_valid && (is_two_reg || is_one_reg);
  assign use_rt     = id_valid && is_two_reg;

  // Producer matches per operand; r0 never creates a dependency
  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  assign ex_rs_hit  = use_rs && (id_rs != 5'd0) && ex_wreg  && (ex_waddr  == id_rs);
  assign ex_rt_hit  = use_rt && (id_rt != 5'd0) && ex_wreg  && (ex_waddr  == id_rt);
  assign mem_rs_hit = use_rs && (id_rs != 5'd0) && mem_wreg && (mem_waddr == id_rs);
  assign mem_rt_hit = use_rt && (id_rt != 5'd0) && mem_wreg && (mem_waddr == id_rt);

  // Stall cycles needed per operand. An EX hit always needs at least as many
  // cycles as any MEM hit, so the EX case alone decides when it matches.
  logic [1:0] need_rs, need_rt, need;
  assign need_rs = ex_rs_hit ? (ex_load ? 2'd2 : 2'd1) :
                   (mem_rs_hit && mem_load) ? 2'd1 : 2'd0;
  assign need_rt = ex_rt_hit ? (ex_load ? 2'd2 : 2'd1) :
                   (mem_rt_hit && mem_load) ? 2'd1 : 2'd0;
  assign need    = (need_rs > need_rt) ? need_rs : need_rt;

  // Control outputs; all forced low while reset is asserted
  logic stall, resolve;
  assign stall   = rst && ((state == S_HOLD) || (is_br && need != 2'd0));
  assign resolve = rst && (state == S_RUN) && is_br && (need == 2'd0);

  assign pc_stall    = stall;
  assign ifid_stall  = stall;
  assign idex_bubble = stall;
  assign pc_sel      = resolve && branch;
  assign ifid_flush  = resolve && branch && !DELAY_SLOT;
  // The younger EX producer shadows MEM, so forwarding from MEM is only
  // valid when EX does not also write the register.
  assign fwd_rs      = rst && mem_rs_hit && !mem_load && !ex_rs_hit;
  assign fwd_rt      = rst && mem_rt_hit && !mem_load && !ex_rt_hit;

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    if (state == S_HOLD) begin
      state_nx = S_RUN;
      rem_nx   = 1'b0;
    end else if (is_br && need == 2'd2) begin
      state_nx = S_HOLD;
      rem_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RUN;
      rem         <= 1'b0;
      br_count    <= '0;
      taken_count <= '0;
      stall_count <= '0;
    end else if (!ext_stall) begin
      state <= state_nx;
      rem   <= rem_nx;
      if (resolve && br_count != CNT_MAX)
        br_count <= br_count + CNT_ONE;
      if (resolve && branch && taken_count != CNT_MAX)
        taken_count <= taken_count + CNT_ONE;
      if (stall && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_ONE;
    end
  end

  assign state_dbg = state;
  assign rem_dbg   = rem;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_TEQ     = 6'b110100;
  localparam logic [5:0] FN_ADDU    = 6'b100001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, branch, ex_wreg, ex_load, mem_wreg, mem_load, ext_stall;
  logic [5:0] id_op, id_func;
  logic [4:0] id_rs, id_rt, ex_waddr, mem_waddr;

  // dut_a: DELAY_SLOT=0, 32-bit counters; dut_b: DELAY_SLOT=1, 4-bit counters
  logic        pc_stall_a, ifid_stall_a, idex_bubble_a, ifid_flush_a, pc_sel_a, fwd_rs_a, fwd_rt_a, rem_a;
  logic [0:0]  state_a;
  logic [31:0] br_a, taken_a, stall_a;
  logic        pc_stall_b, ifid_stall_b, idex_bubble_b, ifid_flush_b, pc_sel_b, fwd_rs_b, fwd_rt_b, rem_b;
  logic [0:0]  state_b;
  logic [3:0]  br_b, taken_b, stall_b;

  logic [6:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pc_stall_a, ifid_stall_a, idex_bubble_a, ifid_flush_a, pc_sel_a, fwd_rs_a, fwd_rt_a};
  assign ctrl_b = {pc_stall_b, ifid_stall_b, idex_bubble_b, ifid_flush_b, pc_sel_b, fwd_rs_b, fwd_rt_b};

  branch_hazard_ctrl #(.DELAY_SLOT(1'b0), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .branch(branch),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_load(ex_load),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_load(mem_load), .ext_stall(ext_stall),
    .pc_stall(pc_stall_a), .ifid_stall(ifid_stall_a), .idex_bubble(idex_bubble_a),
    .ifid_flush(ifid_flush_a), .pc_sel(pc_sel_a), .fwd_rs(fwd_rs_a), .fwd_rt(fwd_rt_a),
    .br_count(br_a), .taken_count(taken_a), .stall_count(stall_a),
    .state_dbg(state_a), .rem_dbg(rem_a)
  );

  branch_hazard_ctrl #(.DELAY_SLOT(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .branch(branch),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_load(ex_load),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_load(mem_load), .ext_stall(ext_stall),
    .pc_stall(pc_stall_b), .ifid_stall(ifid_stall_b), .idex_bubble(idex_bubble_b),
    .ifid_flush(ifid_flush_b), .pc_sel(pc_sel_b), .fwd_rs(fwd_rs_b), .fwd_rt(fwd_rt_b),
    .br_count(br_b), .taken_count(taken_b), .stall_count(stall_b),
    .state_dbg(state_b), .rem_dbg(rem_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_valid = 0; id_op = '0; id_func = '0; id_rs = '0; id_rt = '0; branch = 0;
    ex_wreg = 0; ex_waddr = '0; ex_load = 0;
    mem_wreg = 0; mem_waddr = '0; mem_load = 0; ext_stall = 0;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt);
    id_valid = v; id_op = op; id_func = fn; id_rs = rs; id_rt = rt;
  endtask

  task automatic set_ex(input logic w, input logic [4:0] a, input logic ld);
    ex_wreg = w; ex_waddr = a; ex_load = ld;
  endtask

  task automatic set_mem(input logic w, input logic [4:0] a, input logic ld);
    mem_wreg = w; mem_waddr = a; mem_load = ld;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    step();
    rst = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0;
    set_id(1, OP_BEQ, 6'd0, 5'd3, 5'd4);
    set_ex(1, 5'd3, 1);
    branch = 1;
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b0 || ctrl_b !== 7'b0) begin
      tests_failed++; $display("FAIL reset_ctrl a=%b b=%b exp=0000000", ctrl_a, ctrl_b);
    end
    tests_run++;
    if (br_a !== 0 || taken_a !== 0 || stall_a !== 0 || state_a !== 1'b0 || rem_a !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state br=%0d tk=%0d st=%0d state=%b rem=%b exp all 0",
                               br_a, taken_a, stall_a, state_a, rem_a);
    end
    step();
  endtask

  // beq r3,r4 behind an EX addu writing r3: one stall, then MEM forwarding
  task automatic test_ex_alu();
    do_reset();
    set_id(1, OP_BEQ, 6'd0, 5'd3, 5'd4);
    set_ex(1, 5'd3, 0);
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b1110000) begin
      tests_failed++; $display("FAIL ex_alu_stall ctrl=%b exp=1110000", ctrl_a);
    end
    step();
    set_ex(0, 5'd0, 0);
    set_mem(1, 5'd3, 0);
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b0000010 || state_a !== 1'b0) begin
      tests_failed++; $display("FAIL ex_alu_resolve ctrl=%b state=%b exp=0000010 state 0", ctrl_a, state_a);
    end
    step();
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (br_a !== 1 || taken_a !== 0 || stall_a !== 1) begin
      tests_failed++; $display("FAIL ex_alu_counts br=%0d tk=%0d st=%0d exp 1 0 1", br_a, taken_a, stall_a);
    end
    step();
  endtask

  // bne r5,r0 behind an EX lw writing r5: RUN -> HOLD -> RUN, then taken
  task automatic test_ex_load();
    do_reset();
    set_id(1, OP_BNE, 6'd0, 5'd5, 5'd0);
    set_ex(1, 5'd5, 1);
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b1110000 || state_a !== 1'b0) begin
      tests_failed++; $display("FAIL ld_stall1 ctrl=%b state=%b exp=1110000 state 0", ctrl_a, state_a);
    end
    step();
    set_ex(0, 5'd0, 0);
    set_mem(1, 5'd5, 1);
    branch = 1;
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b1110000 || state_a !== 1'b1 || rem_a !== 1'b1) begin
      tests_failed++; $display("FAIL ld_hold ctrl=%b state=%b rem=%b exp=1110000 state 1 rem 1",
                               ctrl_a, state_a, rem_a);
    end
    step();
    set_mem(0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b0001100 || state_a !== 1'b0 || rem_a !== 1'b0) begin
      tests_failed++; $display("FAIL ld_resolve ctrl=%b state=%b rem=%b exp=0001100 state 0 rem 0",
                               ctrl_a, state_a, rem_a);
    end
    step();
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (br_a !== 1 || taken_a !== 1 || stall_a !== 2) begin
      tests_failed++; $display("FAIL ld_counts br=%0d tk=%0d st=%0d exp 1 1 2", br_a, taken_a, stall_a);
    end
    step();
  endtask

  // jr r31: EX match shadows MEM, then MEM-only forwarding with a taken redirect
  task automatic test_jr_forward();
    do_reset();
    set_id(1, OP_SPECIAL, FN_JR, 5'd31, 5'd0);
    set_ex(1, 5'd31, 0);
    set_mem(1, 5'd31, 0);
    branch = 1;
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b1110000) begin
      tests_failed++; $display("FAIL jr_ex_priority ctrl=%b exp=1110000", ctrl_a);
    end
    step();
    set_ex(1, 5'd7, 0);
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b0001110 || ctrl_b !== 7'b0000110) begin
      tests_failed++; $display("FAIL jr_fwd_taken a=%b b=%b exp a=0001110 b=0000110", ctrl_a, ctrl_b);
    end
    step();
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (taken_a !== 1 || br_a !== 1 || stall_a !== 1) begin
      tests_failed++; $display("FAIL jr_counts br=%0d tk=%0d st=%0d exp 1 1 1", br_a, taken_a, stall_a);
    end
    step();
  endtask

  // beq r0,r0 with EX load writing r0: r0 never stalls; delay slot keeps IF/ID
  task automatic test_r0_delay_slot();
    do_reset();
    set_id(1, OP_BEQ, 6'd0, 5'd0, 5'd0);
    set_ex(1, 5'd0, 1);
    set_mem(1, 5'd0, 0);
    branch = 1;
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b0001100 || ctrl_b !== 7'b0000100) begin
      tests_failed++; $display("FAIL r0_taken a=%b b=%b exp a=0001100 b=0000100", ctrl_a, ctrl_b);
    end
    step();
    clear_inputs();
  endtask

  // Decode table, EX addu -> r5 and MEM addu -> r6 held constant
  logic [29:0] tbl [0:8];
  task automatic test_decode();
    do_reset();
    set_ex(1, 5'd5, 0);
    set_mem(1, 5'd6, 0);
    //           valid op          func      rs     rt     expected ctrl
    tbl[0] = {1'b1, OP_BEQ,     6'd0,    5'd5, 5'd1, 7'b1110000};
    tbl[1] = {1'b1, OP_BEQ,     6'd0,    5'd1, 5'd5, 7'b1110000};
    tbl[2] = {1'b1, OP_REGIMM,  6'd0,    5'd1, 5'd5, 7'b0000000};
    tbl[3] = {1'b1, OP_J,       6'd0,    5'd5, 5'd6, 7'b0000000};
    tbl[4] = {1'b1, OP_SPECIAL, FN_JALR, 5'd6, 5'd0, 7'b0000010};
    tbl[5] = {1'b1, OP_SPECIAL, FN_ADDU, 5'd5, 5'd6, 7'b0000000};
    tbl[6] = {1'b1, OP_SPECIAL, FN_TEQ,  5'd6, 5'd5, 7'b1110010};
    tbl[7] = {1'b0, OP_BEQ,     6'd0,    5'd5, 5'd6, 7'b0000000};
    tbl[8] = {1'b1, OP_BNE,     6'd0,    5'd6, 5'd6, 7'b0000011};
    for (int i = 0; i < 9; i++) begin
      set_id(tbl[i][29], tbl[i][28:23], tbl[i][22:17], tbl[i][16:12], tbl[i][11:7]);
      @(negedge clk);
      tests_run++;
      if (ctrl_a !== tbl[i][6:0]) begin
        tests_failed++; $display("FAIL decode_row%0d ctrl=%b exp=%b", i, ctrl_a, tbl[i][6:0]);
      end
      step();
    end
    // teq with MEM load on rt: one stall
    set_ex(0, 5'd0, 0);
    set_mem(1, 5'd9, 1);
    set_id(1, OP_SPECIAL, FN_TEQ, 5'd2, 5'd9);
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b1110000 || state_a !== 1'b0) begin
      tests_failed++; $display("FAIL mem_load_rt ctrl=%b state=%b exp=1110000 state 0", ctrl_a, state_a);
    end
    step();
    clear_inputs();
  endtask

  // Reset pulsed during HOLD abandons the stall
  task automatic test_reset_in_hold();
    do_reset();
    set_id(1, OP_BNE, 6'd0, 5'd5, 5'd0);
    set_ex(1, 5'd5, 1);
    step();
    @(negedge clk);
    tests_run++;
    if (state_a !== 1'b1 || ctrl_a !== 7'b1110000) begin
      tests_failed++; $display("FAIL hold_entry state=%b ctrl=%b exp state 1 1110000", state_a, ctrl_a);
    end
    #2 rst = 0;
    #1;
    tests_run++;
    if (ctrl_a !== 7'b0 || stall_a !== 0 || state_a !== 1'b0 || rem_a !== 1'b0) begin
      tests_failed++; $display("FAIL hold_async_rst ctrl=%b st=%0d state=%b rem=%b exp all 0",
                               ctrl_a, stall_a, state_a, rem_a);
    end
    step();
    step();
    rst = 1;
    set_ex(0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (state_a !== 1'b0 || ctrl_a !== 7'b0) begin
      tests_failed++; $display("FAIL hold_release state=%b ctrl=%b exp state 0 0000000", state_a, ctrl_a);
    end
    step();
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (br_a !== 1 || stall_a !== 0) begin
      tests_failed++; $display("FAIL hold_release_counts br=%0d st=%0d exp 1 0", br_a, stall_a);
    end
    step();
  endtask

  // ext_stall freezes FSM and counters while outputs stay live
  task automatic test_ext_stall();
    do_reset();
    set_id(1, OP_BEQ, 6'd0, 5'd3, 5'd4);
    set_ex(1, 5'd3, 1);
    ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (ctrl_a !== 7'b1110000 || state_a !== 1'b0) begin
        tests_failed++; $display("FAIL ext_frozen%0d ctrl=%b state=%b exp=1110000 state 0", i, ctrl_a, state_a);
      end
      step();
    end
    set_ex(0, 5'd0, 0);
    branch = 1;
    @(negedge clk);
    tests_run++;
    if (ctrl_a !== 7'b0001100) begin
      tests_failed++; $display("FAIL ext_resolve_live ctrl=%b exp=0001100", ctrl_a);
    end
    step();
    ext_stall = 0;
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (stall_a !== 0 || br_a !== 0 || taken_a !== 0) begin
      tests_failed++; $display("FAIL ext_counts br=%0d tk=%0d st=%0d exp 0 0 0", br_a, taken_a, stall_a);
    end
    step();
  endtask

  // 20 taken branches: 4-bit counters saturate at 15
  task automatic test_saturation();
    do_reset();
    set_id(1, OP_BEQ, 6'd0, 5'd0, 5'd0);
    branch = 1;
    for (int i = 0; i < 20; i++) step();
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (taken_b !== 4'd15 || br_b !== 4'd15) begin
      tests_failed++; $display("FAIL sat_b br=%0d tk=%0d exp 15 15", br_b, taken_b);
    end
    tests_run++;
    if (taken_a !== 20 || br_a !== 20) begin
      tests_failed++; $display("FAIL sat_a_ref br=%0d tk=%0d exp 20 20", br_a, taken_a);
    end
    step();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_ex_alu();
    test_ex_load();
    test_jr_forward();
    test_r0_delay_slot();
    test_decode();
    test_reset_in_hold();
    test_ext_stall();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
